switch_event_queue: RTL and testbench
=====================================

# switch_event_queue

Converts the debounced switch/key level vector from the multi-switch debouncer into a queue of discrete press events: one event per rising edge of each debounced input. Events are delivered one at a time as a switch index over a valid/ready handshake to the game FSM, so that FSM consumes whacks and key presses without doing its own edge detection. It sits directly downstream of the debouncer, on the same clock.

## Interface
- NUM_SWITCHES, 22: width of debounced input vector (SW[17:0] at bits 17:0, KEY[3:0] at bits 21:18)
- FIFO_DEPTH, 4: event queue depth, power of two, >= 2
- IDX_W, $clog2(NUM_SWITCHES): width of event index
- CNT_W, $clog2(FIFO_DEPTH)+1: width of fifo_count

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-high reset
- button_pressed  input  NUM_SWITCHES  debounced levels, 1 = pressed
- event_valid  output  1  head of queue holds an event
- event_index  output  IDX_W  switch index of head event; 0 when event_valid=0
- event_ready  input  1  consumer accepts head event this cycle
- pending  output  NUM_SWITCHES  edges captured but not yet enqueued
- fifo_count  output  CNT_W  events currently queued, 0..FIFO_DEPTH
- overflow  output  1  sticky: an edge was lost

## Operation
- Edge detect: register prev <= button_pressed every cycle; rise = button_pressed & ~prev. Falling edges ignored.
- Reset loads prev <= button_pressed, so no event is produced for inputs already high at reset. Reset clears pending, FIFO pointers, fifo_count, overflow; event_valid=0, event_index=0.
- Capture: pending <= (pending & ~clear_mask) | rise, where clear_mask is the one-hot of the bit enqueued this cycle.
- Lost edge: rise[i]=1 while pending[i]=1 (and i not enqueued this cycle) -> overflow <= 1. pending[i] stays 1 (events coalesce). overflow is cleared only by reset.
- Scanner: each cycle selects the lowest-index set bit of registered pending. It enqueues at most one event per cycle, allowed when fifo_count < FIFO_DEPTH, or when fifo_count == FIFO_DEPTH and a pop occurs the same cycle.
- FIFO: show-ahead. event_valid = (fifo_count != 0); event_index = head entry. Pop on event_valid & event_ready. Read/write pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves fifo_count unchanged.
- event_ready while event_valid=0 has no effect.
- Ordering: events from different cycles are delivered in capture-to-enqueue order. Simultaneous rises are delivered lowest index first.

## Timing
- Input rises before edge k -> pending bit set at edge k -> enqueued at edge k+1 (if room) -> event_valid=1 after edge k+1. Latency is 2 cycles, input to valid.
- With event_ready held at 1, each event is valid for exactly 1 cycle. Sustained throughput is 1 event/cycle.
- N simultaneous rises with an empty FIFO and ready=1 produce events on N consecutive cycles.
- Backpressure: with ready=0, the FIFO fills to FIFO_DEPTH. Further edges are held in pending, one per bit, without loss until a second rise on the same bit.
- Reset asserted mid-operation: all state is cleared at the next edge regardless of handshake. Any queued or pending event is discarded. The first cycle after reset has event_valid=0.

## Test plan
- Hold button_pressed[3]=1 through reset, deassert reset, run 10 cycles -> event_valid stays 0, pending=0, overflow=0.
- Empty queue, event_ready=1, raise bit 5 -> event_valid=1 with event_index=5 exactly 2 cycles later for 1 cycle; fifo_count returns to 0.
- event_ready=0, raise bits 0, 7, 21 in the same cycle -> fifo_count reaches 3 within 3 cycles. Assert ready -> indices 0, 7, 21 delivered on 3 consecutive cycles.
- FIFO_DEPTH=4, event_ready=0, raise bits 1,2,3,4,8,9 together -> fifo_count=4, pending has bits 8 and 9 set, overflow=0. Assert ready -> 1,2,3,4,8,9 delivered in order.
- FIFO full with bit 9 pending: drop and re-raise bit 9 -> overflow=1 and stays 1 after draining; only one event for index 9 is delivered.
- With 3 events queued and bits pending, pulse reset for 1 cycle -> next cycle fifo_count=0, pending=0, event_valid=0, event_index=0, overflow=0.

Source files
------------

// File: rtl/switch_event_queue.sv
// switch_event_queue: turns debounced switch levels into a queue of press
// events, delivered one switch index at a time over valid/ready.
module switch_event_queue #(
    parameter int NUM_SWITCHES = 22,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDX_W        = $clog2(NUM_SWITCHES),
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SWITCHES-1:0] button_pressed,
    output logic                    event_valid,
    output logic [IDX_W-1:0]        event_index,
    input  logic                    event_ready,
    output logic [NUM_SWITCHES-1:0] pending,
    output logic [CNT_W-1:0]        fifo_count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [NUM_SWITCHES-1:0] prev;
    logic [NUM_SWITCHES-1:0] rise;
    logic [NUM_SWITCHES-1:0] sel_mask;
    logic [NUM_SWITCHES-1:0] clear_mask;
    logic [IDX_W-1:0]        scan_idx;
    logic [IDX_W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic                    pop;
    logic                    push;
    logic                    room;

    assign rise = button_pressed & ~prev;

    // x & -x isolates the lowest set bit of pending
    assign sel_mask = pending & (~pending + NUM_SWITCHES'(1));

    always_comb begin
        scan_idx = '0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            if (sel_mask[i]) begin
                scan_idx = scan_idx | IDX_W'(i);
            end
        end
    end

    assign event_valid = (fifo_count != '0);
    assign event_index = event_valid ? mem[rd_ptr] : '0;
    assign pop         = event_valid & event_ready;
    assign room        = (fifo_count != FULL) | pop;
    assign push        = (|pending) & room;
    assign clear_mask  = push ? sel_mask : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= button_pressed;
            pending    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            prev    <= button_pressed;
            pending <= (pending & ~clear_mask) | rise;
            // a second rise on a still-pending bit coalesces and is lost
            if (|(rise & pending & ~clear_mask)) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= scan_idx;
        end
    end

endmodule

// File: tb/tb_switch_event_queue.sv
// tb_switch_event_queue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_switch_event_queue;

    localparam int NS = 22;
    localparam int D  = 4;

    logic          clk;
    logic          reset;
    logic [NS-1:0] button_pressed;
    logic          event_valid;
    logic [4:0]    event_index;
    logic          event_ready;
    logic [NS-1:0] pending;
    logic [2:0]    fifo_count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    switch_event_queue dut (
        .clk            (clk),
        .reset          (reset),
        .button_pressed (button_pressed),
        .event_valid    (event_valid),
        .event_index    (event_index),
        .event_ready    (event_ready),
        .pending        (pending),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NS-1:0] btn;
        logic          rdy;
        logic          ev;
        logic [4:0]    idx;
        logic [2:0]    cnt;
        logic [NS-1:0] pend;
        logic          ovf;
    } vec_t;

    vec_t tbl [12];

    localparam logic [NS-1:0] B0  = 22'd1 << 0;
    localparam logic [NS-1:0] B5  = 22'd1 << 5;
    localparam logic [NS-1:0] B7  = 22'd1 << 7;
    localparam logic [NS-1:0] B8  = 22'd1 << 8;
    localparam logic [NS-1:0] B9  = 22'd1 << 9;
    localparam logic [NS-1:0] B13 = 22'd1 << 13;
    localparam logic [NS-1:0] B14 = 22'd1 << 14;
    localparam logic [NS-1:0] B21 = 22'd1 << 21;
    localparam logic [NS-1:0] TRI = B0 | B7 | B21;
    localparam logic [NS-1:0] SIX = 22'h00031E;
    localparam logic [NS-1:0] FIVE = 22'h1F << 10;

    int          q[$];
    logic [NS-1:0] m_pend;
    logic [NS-1:0] m_prev;
    logic          m_ovf;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: one clock edge computed from the queue-level rules.
    task automatic model_edge();
        int sel;
        bit do_pop;
        logic [NS-1:0] rise_m;
        if (reset) begin
            m_prev = button_pressed;
            m_pend = '0;
            q.delete();
            m_ovf  = 1'b0;
        end else begin
            do_pop = (q.size() > 0) && event_ready;
            sel = -1;
            for (int i = NS - 1; i >= 0; i--) begin
                if (m_pend[i]) sel = i;
            end
            rise_m = button_pressed & ~m_prev;
            if (do_pop) void'(q.pop_front());
            if (sel >= 0 && (q.size() < D)) begin
                q.push_back(sel);
                m_pend[sel] = 1'b0;
            end
            if ((rise_m & m_pend) != '0) m_ovf = 1'b1;
            m_pend = m_pend | rise_m;
            m_prev = button_pressed;
        end
    endtask

    initial begin
        int got[$];
        int exp_seq[6];
        exp_seq = '{1, 2, 3, 4, 8, 9};

        tbl[0]  = '{1'b1, 22'd0, 1'b1, 1'b0, 5'd0,  3'd0, 22'd0, 1'b0};
        tbl[1]  = '{1'b0, B5,    1'b1, 1'b0, 5'd0,  3'd0, B5,    1'b0};
        tbl[2]  = '{1'b0, B5,    1'b1, 1'b1, 5'd5,  3'd1, 22'd0, 1'b0};
        tbl[3]  = '{1'b0, B5,    1'b1, 1'b0, 5'd0,  3'd0, 22'd0, 1'b0};
        tbl[4]  = '{1'b0, 22'd0, 1'b1, 1'b0, 5'd0,  3'd0, 22'd0, 1'b0};
        tbl[5]  = '{1'b0, TRI,   1'b0, 1'b0, 5'd0,  3'd0, TRI,   1'b0};
        tbl[6]  = '{1'b0, TRI,   1'b0, 1'b1, 5'd0,  3'd1, B7 | B21, 1'b0};
        tbl[7]  = '{1'b0, TRI,   1'b0, 1'b1, 5'd0,  3'd2, B21,   1'b0};
        tbl[8]  = '{1'b0, TRI,   1'b0, 1'b1, 5'd0,  3'd3, 22'd0, 1'b0};
        tbl[9]  = '{1'b0, TRI,   1'b1, 1'b1, 5'd7,  3'd2, 22'd0, 1'b0};
        tbl[10] = '{1'b0, TRI,   1'b1, 1'b1, 5'd21, 3'd1, 22'd0, 1'b0};
        tbl[11] = '{1'b0, TRI,   1'b1, 1'b0, 5'd0,  3'd0, 22'd0, 1'b0};

        // Input high through reset must not produce an event
        reset = 1'b1;
        button_pressed = 22'd1 << 3;
        event_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("hold_ev%0d", i), 32'(event_valid), 32'd0);
            chk($sformatf("hold_pend%0d", i), 32'(pending), 32'd0);
            chk($sformatf("hold_ovf%0d", i), 32'(overflow), 32'd0);
        end
        button_pressed = '0;
        step();

        for (int v = 0; v < 12; v++) begin
            reset = tbl[v].rst;
            button_pressed = tbl[v].btn;
            event_ready = tbl[v].rdy;
            step();
            chk($sformatf("vec%0d_ev", v), 32'(event_valid), 32'(tbl[v].ev));
            chk($sformatf("vec%0d_idx", v), 32'(event_index), 32'(tbl[v].idx));
            chk($sformatf("vec%0d_cnt", v), 32'(fifo_count), 32'(tbl[v].cnt));
            chk($sformatf("vec%0d_pend", v), 32'(pending), 32'(tbl[v].pend));
            chk($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(tbl[v].ovf));
        end

        // Fill under backpressure, leftovers held in pending
        button_pressed = '0;
        event_ready = 1'b0;
        step();
        button_pressed = SIX;
        for (int i = 0; i < 5; i++) step();
        chk("full_cnt", 32'(fifo_count), 32'd4);
        chk("full_pend", 32'(pending), 32'(B8 | B9));
        chk("full_ovf", 32'(overflow), 32'd0);
        chk("full_head", 32'(event_index), 32'd1);
        step();
        chk("full_hold_cnt", 32'(fifo_count), 32'd4);

        // Second rise on pending bit 9 is lost and flagged
        button_pressed = SIX & ~B9;
        step();
        chk("drop9_ovf", 32'(overflow), 32'd0);
        chk("drop9_pend", 32'(pending), 32'(B8 | B9));
        button_pressed = SIX;
        step();
        chk("rerise9_ovf", 32'(overflow), 32'd1);
        chk("rerise9_pend", 32'(pending), 32'(B8 | B9));

        event_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            if (event_valid) got.push_back(int'(event_index));
            step();
        end
        chk("drain_len", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size() && i < 6; i++) begin
            chk($sformatf("drain_idx%0d", i), 32'(got[i]), 32'(exp_seq[i]));
        end
        step();
        chk("drained_cnt", 32'(fifo_count), 32'd0);
        chk("drained_ev", 32'(event_valid), 32'd0);
        chk("drained_ovf", 32'(overflow), 32'd1);
        chk("drained_pend", 32'(pending), 32'd0);

        // Reset mid-operation discards queued and pending events
        button_pressed = '0;
        event_ready = 1'b0;
        step();
        button_pressed = FIVE;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_cnt", 32'(fifo_count), 32'd3);
        chk("pre_rst_pend", 32'(pending), 32'(B13 | B14));
        reset = 1'b1;
        step();
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_ev", 32'(event_valid), 32'd0);
        chk("rst_idx", 32'(event_index), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ev", 32'(event_valid), 32'd0);
        chk("post_rst_pend", 32'(pending), 32'd0);

        // Randomized run against the reference model
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                reset = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 2) == 0)
                    button_pressed[$urandom_range(0, NS - 1)] ^= 1'b1;
                if ($urandom_range(0, 19) == 0)
                    button_pressed ^= NS'($urandom);
                event_ready = (c < 1500) ? ($urandom_range(0, 9) < 3)
                                         : ($urandom_range(0, 9) < 8);
            end
            model_edge();
            step();
            chk($sformatf("rnd%0d_ev", c), 32'(event_valid),
                32'(q.size() > 0));
            chk($sformatf("rnd%0d_idx", c), 32'(event_index),
                (q.size() > 0) ? 32'(q[0]) : 32'd0);
            chk($sformatf("rnd%0d_cnt", c), 32'(fifo_count), 32'(q.size()));
            chk($sformatf("rnd%0d_pend", c), 32'(pending), 32'(m_pend));
            chk($sformatf("rnd%0d_ovf", c), 32'(overflow), 32'(m_ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
